// File: rtl/dmem_ctrl.sv
// Data-memory stage: word-organised RAM with byte/half/word lanes, sign extension and a busy/done handshake.
// Optional misalignment trapping is enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_ctrl #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read_dmem,
  input  logic        write_dmem,
  input  logic [31:0] addr_dmem,
  input  logic [31:0] write_data_dmem,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  output logic [31:0] read_data_dmem,
  output logic        dmem_busy,
  output logic        dmem_done,
  output logic        dmem_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t        r_state, w_next;
  logic [3:0]    r_cnt;
  logic          r_we;
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [1:0]    r_size;
  logic          r_unsigned;
  logic [31:0]   r_rdata;
  logic [31:0]   r_mem [DEPTH];

  logic          w_commit;
  logic          w_misalign;
  logic [AW+1:0] w_addr;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic [3:0]    w_be;
  logic [31:0]   w_wlane;
  logic [31:0]   w_rword;
  logic [31:0]   w_shift;
  logic [31:0]   w_load;
  logic          w_unused_addr;

  // Address bits above the RAM window alias onto it.
  assign w_unused_addr = &{1'b0, addr_dmem[31:AW+2]};

  assign w_commit = (r_state == S_ACCESS) && (r_cnt == 4'd0);

`ifdef DMEM_MISALIGN_TRAP_EN
  logic r_err;

  assign w_misalign = ((r_size == 2'b01) && r_addr[0]) ||
                      (r_size[1] && (r_addr[1:0] != 2'b00));
  assign w_addr     = r_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_err <= 1'b0;
    else if (w_commit) r_err <= w_misalign;
  end

  assign dmem_err = (r_state == S_DONE) && r_err;
`else
  assign w_misalign = 1'b0;
  assign dmem_err   = 1'b0;

  always_comb begin
    w_addr = r_addr;
    if (r_size == 2'b01) w_addr[0]   = 1'b0;
    if (r_size[1])       w_addr[1:0] = 2'b00;
  end
`endif

  assign w_idx  = w_addr[AW+1:2];
  assign w_lane = w_addr[1:0];

  always_comb begin
    w_be    = 4'b1111;
    w_wlane = r_wdata;
    case (r_size)
      2'b00: begin
        w_be    = 4'b0001 << w_lane;
        w_wlane = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wlane = {2{r_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_rword = r_mem[w_idx];
  assign w_shift = w_rword >> {w_lane, 3'b000};

  always_comb begin
    w_load = w_shift;
    case (r_size)
      2'b00:   w_load = r_unsigned ? {24'd0, w_shift[7:0]}  : {{24{w_shift[7]}},  w_shift[7:0]};
      2'b01:   w_load = r_unsigned ? {16'd0, w_shift[15:0]} : {{16{w_shift[15]}}, w_shift[15:0]};
      default: w_load = w_rword;
    endcase
    if (w_misalign) w_load = 32'd0;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (read_dmem || write_dmem) w_next = S_ACCESS;
      S_ACCESS: if (r_cnt == 4'd0) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_rdata    <= 32'd0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && (read_dmem || write_dmem)) begin
        r_we       <= write_dmem;
        r_addr     <= addr_dmem[AW+1:0];
        r_wdata    <= write_data_dmem;
        r_size     <= mem_size;
        r_unsigned <= mem_unsigned;
        r_cnt      <= 4'(WAIT_STATES);
      end else if ((r_state == S_ACCESS) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit && !r_we) r_rdata <= w_load;
    end
  end

  // RAM array is intentionally not reset; stores commit per-byte on the final ACCESS cycle.
  always_ff @(posedge clk) begin
    if (w_commit && r_we && !w_misalign) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
      end
    end
  end

  assign read_data_dmem = r_rdata;
  assign dmem_busy      = (r_state != S_IDLE);
  assign dmem_done      = (r_state == S_DONE);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: lanes, extension, handshake timing, write-wins, wrap, misalign, async reset.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        read_dmem, write_dmem;
  logic [31:0] addr_dmem, write_data_dmem;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] read_data_dmem;
  logic        dmem_busy, dmem_done, dmem_err;

  int errors = 0;
  int checks = 0;

  localparam int EXP_LAT = 3;

  dmem_ctrl #(.DEPTH(1024), .WAIT_STATES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .read_dmem(read_dmem), .write_dmem(write_dmem),
    .addr_dmem(addr_dmem), .write_data_dmem(write_data_dmem),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .read_data_dmem(read_data_dmem), .dmem_busy(dmem_busy),
    .dmem_done(dmem_done), .dmem_err(dmem_err)
  );

  always #5 clk = ~clk;

  // Issues one request at posedge+1 and follows it to its done pulse (bounded) plus one trailing cycle.
  task automatic access(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic u,
                        output logic [31:0] rd, output int lat, output logic er,
                        output int busy_bad, output logic tail_bad);
    write_dmem = we; read_dmem = re; addr_dmem = a; write_data_dmem = d;
    mem_size = sz; mem_unsigned = u;
    @(posedge clk); #1;
    write_dmem = 1'b0; read_dmem = 1'b0;
    lat = 0; busy_bad = 0; er = 1'b0; tail_bad = 1'b0; rd = 32'd0;
    for (int k = 1; k <= 40; k++) begin
      lat = k;
      if (!dmem_busy) busy_bad++;
      if (dmem_done) break;
      @(posedge clk); #1;
    end
    rd = read_data_dmem; er = dmem_err;
    @(posedge clk); #1;
    tail_bad = dmem_done | dmem_busy;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    logic [31:0] rd; int lat; logic er; int bb; logic tb;
    access(1'b1, 1'b0, a, d, sz, 1'b0, rd, lat, er, bb, tb);
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic u, output logic [31:0] rd);
    int lat; logic er; int bb; logic tb;
    access(1'b0, 1'b1, a, 32'd0, sz, u, rd, lat, er, bb, tb);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; read_dmem = 1'b0; write_dmem = 1'b0; addr_dmem = '0;
    write_data_dmem = '0; mem_size = 2'b10; mem_unsigned = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (read_data_dmem !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", read_data_dmem); end
    checks++; if (dmem_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", dmem_busy); end
    checks++; if (dmem_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", dmem_done); end
    checks++; if (dmem_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", dmem_err); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word;
    logic [31:0] rd; int lat; logic er; int bb; logic tb;
    access(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, rd, lat, er, bb, tb);
    checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL sw_latency got=%0d exp=%0d", lat, EXP_LAT); end
    checks++; if (bb !== 0) begin errors++; $display("FAIL sw_busy_gaps got=%0d exp=0", bb); end
    checks++; if (tb !== 1'b0) begin errors++; $display("FAIL sw_tail_idle got=%b exp=0", tb); end
    access(1'b0, 1'b1, 32'h10, 32'd0, 2'b10, 1'b0, rd, lat, er, bb, tb);
    checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL lw_latency got=%0d exp=%0d", lat, EXP_LAT); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got=%h exp=DEADBEEF", rd); end
  endtask

  task automatic test_byte;
    logic [31:0] rd;
    store(32'h10, 32'h0, 2'b10);
    store(32'h13, 32'h80, 2'b00);
    load(32'h13, 2'b00, 1'b0, rd);
    checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb got=%h exp=FFFFFF80", rd); end
    load(32'h13, 2'b00, 1'b1, rd);
    checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu got=%h exp=00000080", rd); end
    load(32'h10, 2'b10, 1'b0, rd);
    checks++; if (rd !== 32'h80000000) begin errors++; $display("FAIL lw_after_sb got=%h exp=80000000", rd); end
  endtask

  task automatic test_half;
    logic [31:0] rd;
    store(32'h20, 32'hCAFEBABE, 2'b10);
    store(32'h22, 32'h1234, 2'b01);
    load(32'h22, 2'b01, 1'b1, rd);
    checks++; if (rd !== 32'h00001234) begin errors++; $display("FAIL lhu got=%h exp=00001234", rd); end
    load(32'h20, 2'b10, 1'b0, rd);
    checks++; if (rd !== 32'h1234BABE) begin errors++; $display("FAIL lw_after_sh got=%h exp=1234BABE", rd); end
    store(32'h20, 32'h8001, 2'b01);
    load(32'h20, 2'b01, 1'b0, rd);
    checks++; if (rd !== 32'hFFFF8001) begin errors++; $display("FAIL lh got=%h exp=FFFF8001", rd); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] prev, rd;
    int n_done;
    prev = read_data_dmem;
    write_dmem = 1'b1; read_dmem = 1'b1; addr_dmem = 32'h40; write_data_dmem = 32'h55;
    mem_size = 2'b10; mem_unsigned = 1'b0;
    @(posedge clk); #1;
    write_dmem = 1'b0; read_dmem = 1'b0;
    n_done = 0;
    for (int k = 0; k < 10; k++) begin
      if (dmem_done) n_done++;
      read_dmem = (k == 1);
      addr_dmem = (k == 1) ? 32'h10 : 32'h40;
      @(posedge clk); #1;
    end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL both_done_count got=%0d exp=1", n_done); end
    checks++; if (read_data_dmem !== prev) begin errors++; $display("FAIL store_keeps_rdata got=%h exp=%h", read_data_dmem, prev); end
    load(32'h40, 2'b10, 1'b0, rd);
    checks++; if (rd !== 32'h55) begin errors++; $display("FAIL both_store_data got=%h exp=00000055", rd); end
  endtask

  task automatic test_wrap;
    logic [31:0] rd;
    store(32'h1000, 32'h11223344, 2'b10);
    load(32'h0, 2'b10, 1'b0, rd);
    checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL wrap got=%h exp=11223344", rd); end
  endtask

  task automatic test_misalign;
    logic [31:0] rd; int lat; logic er; int bb; logic tb;
    store(32'h04, 32'h0BADF00D, 2'b10);
    access(1'b0, 1'b1, 32'h06, 32'd0, 2'b10, 1'b0, rd, lat, er, bb, tb);
    checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL misalign_latency got=%0d exp=%0d", lat, EXP_LAT); end
`ifdef DMEM_MISALIGN_TRAP_EN
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL misalign_data got=%h exp=00000000", rd); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL misalign_err got=%b exp=1", er); end
`else
    checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL misalign_data got=%h exp=0BADF00D", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL misalign_err got=%b exp=0", er); end
`endif
  endtask

  task automatic test_reset_mid_access;
    logic [31:0] rd;
    write_dmem = 1'b1; addr_dmem = 32'h0; write_data_dmem = 32'hA5A5A5A5; mem_size = 2'b10;
    @(posedge clk); #1;
    write_dmem = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (read_data_dmem !== 32'd0) begin errors++; $display("FAIL midrst_rdata got=%h exp=0", read_data_dmem); end
    checks++; if (dmem_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", dmem_busy); end
    checks++; if (dmem_done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", dmem_done); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    load(32'h0, 2'b10, 1'b0, rd);
    checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL midrst_old_value got=%h exp=11223344", rd); end
  endtask

  initial begin
    test_reset;
    test_word;
    test_byte;
    test_half;
    test_back_to_back;
    test_wrap;
    test_misalign;
    test_reset_mid_access;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
